// File: rtl/ascii_cmd_parser_pkg.sv
// Shared ASCII constants, command/error codes and small helpers for the
// ASCII command parser (the ASCII constants are also used by the sender).
package ascii_cmd_parser_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_Q     = 8'h51;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_B     = 8'h42;
    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_U     = 8'h55;
    localparam logic [7:0] ASCII_D     = 8'h44;
    localparam logic [7:0] ASCII_L     = 8'h4C;
    localparam logic [7:0] ASCII_R     = 8'h52;

    localparam logic [1:0] CMD_NONE     = 2'd0;
    localparam logic [1:0] CMD_QUERY    = 2'd1;
    localparam logic [1:0] CMD_SET_TIME = 2'd2;
    localparam logic [1:0] CMD_BUTTON   = 2'd3;

    localparam logic [1:0] ERR_TIMEOUT  = 2'd0;
    localparam logic [1:0] ERR_UNKNOWN  = 2'd1;
    localparam logic [1:0] ERR_FORMAT   = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARG     = 2'd1,
        ST_DISCARD = 2'd2
    } parser_state_e;

    function automatic logic is_terminator(input logic [7:0] ch);
        return (ch == ASCII_CR) || (ch == ASCII_LF);
    endfunction

    // Number of characters expected after the command letter.
    function automatic logic [3:0] expected_len(input logic [1:0] cmd);
        case (cmd)
            CMD_SET_TIME: return 4'd8;
            CMD_QUERY,
            CMD_BUTTON:   return 4'd1;
            default:      return 4'd0;
        endcase
    endfunction

    // Bit 0..4 = C,U,D,L,R; zero for any other character.
    function automatic logic [4:0] button_onehot(input logic [7:0] ch);
        case (ch)
            ASCII_C: return 5'b00001;
            ASCII_U: return 5'b00010;
            ASCII_D: return 5'b00100;
            ASCII_L: return 5'b01000;
            ASCII_R: return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/ascii_cmd_parser_digit_check.sv
// Combinational classifier for one received character: decimal digit test,
// digit value and the <=2 / <=3 / <=5 range flags used by the time grammar.
module ascii_digit_check
    import ascii_cmd_parser_pkg::*;
(
    input  logic [7:0] i_char,
    output logic       o_is_digit,
    output logic [3:0] o_value,
    output logic       o_le2,
    output logic       o_le3,
    output logic       o_le5
);

    assign o_is_digit = (i_char >= ASCII_0) && (i_char <= (ASCII_0 + 8'd9));
    assign o_value    = i_char[3:0];
    assign o_le2      = o_is_digit && (i_char <= (ASCII_0 + 8'd2));
    assign o_le3      = o_is_digit && (i_char <= (ASCII_0 + 8'd3));
    assign o_le5      = o_is_digit && (i_char <= (ASCII_0 + 8'd5));

endmodule

// File: rtl/ascii_cmd_parser.sv
// Parses CR/LF-terminated ASCII command lines (Q<d>, SHH:MM:SS, B<btn>) from
// the UART receive stream into one command or error pulse per line.
module ascii_cmd_parser
    import ascii_cmd_parser_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 100_000_000,
    parameter int TO_W        = 27
) (
    input  logic        iClk,
    input  logic        iRstn,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_cmd_valid,
    output logic [1:0]  o_cmd_code,
    output logic [31:0] o_cmd_arg,
    output logic        o_err_valid,
    output logic [1:0]  o_err_code,
    output logic        o_line_active
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [TO_W-1:0]  TO_LAST = (TIMEOUT_CYC == 0) ? '0 : TO_W'(TIMEOUT_CYC - 1);

    parser_state_e    state_q, state_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [1:0]       err_q, err_d;
    logic [3:0]       pos_q, pos_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [23:0]      arg_sr_q, arg_sr_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [1:0]       cmd_code_q, cmd_code_d;
    logic [31:0]      cmd_arg_q, cmd_arg_d;
    logic             err_valid_q, err_valid_d;
    logic [1:0]       err_code_q, err_code_d;

    logic       is_digit, le2, le3, le5;
    logic [3:0] digit_val;
    logic [4:0] btn_onehot;
    logic       is_term, len_full, timeout_hit, char_ok;
    logic [3:0] exp_len;
    logic [31:0] arg_final;

    ascii_digit_check u_digit_check (
        .i_char     (i_rx_data),
        .o_is_digit (is_digit),
        .o_value    (digit_val),
        .o_le2      (le2),
        .o_le3      (le3),
        .o_le5      (le5)
    );

    assign btn_onehot  = button_onehot(i_rx_data);
    assign is_term     = is_terminator(i_rx_data);
    assign exp_len     = expected_len(cmd_q);
    assign len_full    = (len_q >= LEN_MAX);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (to_cnt_q == TO_LAST);

    // Grammar check of the current byte at position pos_q of the argument.
    always_comb begin
        char_ok = 1'b0;
        case (cmd_q)
            CMD_QUERY:  char_ok = le3;
            CMD_BUTTON: char_ok = (btn_onehot != 5'b00000);
            CMD_SET_TIME: begin
                case (pos_q)
                    4'd0:       char_ok = le2;
                    4'd1:       char_ok = is_digit && ((arg_sr_q[3:0] != 4'd2) || le3);
                    4'd2, 4'd5: char_ok = (i_rx_data == ASCII_COLON);
                    4'd3, 4'd6: char_ok = le5;
                    default:    char_ok = is_digit;
                endcase
            end
            default: char_ok = 1'b0;
        endcase
    end

    always_comb begin
        arg_final = 32'h0;
        case (cmd_q)
            CMD_QUERY:    arg_final = {30'b0, arg_sr_q[1:0]};
            CMD_SET_TIME: arg_final = {arg_sr_q, 8'h00};
            CMD_BUTTON:   arg_final = {27'b0, arg_sr_q[4:0]};
            default:      arg_final = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        err_d       = err_q;
        pos_d       = pos_q;
        len_d       = len_q;
        arg_sr_d    = arg_sr_q;
        to_cnt_d    = to_cnt_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        cmd_arg_d   = cmd_arg_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;

        case (state_q)
            ST_IDLE: begin
                to_cnt_d = '0;
                if (i_rx_valid && !is_term) begin
                    pos_d    = 4'd0;
                    len_d    = LEN_W'(1);
                    arg_sr_d = 24'h0;
                    err_d    = ERR_FORMAT;
                    state_d  = ST_ARG;
                    case (i_rx_data)
                        ASCII_Q: cmd_d = CMD_QUERY;
                        ASCII_S: cmd_d = CMD_SET_TIME;
                        ASCII_B: cmd_d = CMD_BUTTON;
                        default: begin
                            cmd_d   = CMD_NONE;
                            err_d   = ERR_UNKNOWN;
                            state_d = ST_DISCARD;
                        end
                    endcase
                end
            end

            ST_ARG: begin
                if (i_rx_valid) begin
                    to_cnt_d = '0;
                    if (is_term) begin
                        state_d = ST_IDLE;
                        if (pos_q == exp_len) begin
                            cmd_valid_d = 1'b1;
                            cmd_code_d  = cmd_q;
                            cmd_arg_d   = arg_final;
                        end else begin
                            err_valid_d = 1'b1;
                            err_code_d  = ERR_FORMAT;
                        end
                    end else if (len_full) begin
                        err_d   = ERR_OVERFLOW;
                        state_d = ST_DISCARD;
                    end else if ((pos_q >= exp_len) || !char_ok) begin
                        err_d   = ERR_FORMAT;
                        len_d   = len_q + LEN_W'(1);
                        state_d = ST_DISCARD;
                    end else begin
                        pos_d = pos_q + 4'd1;
                        len_d = len_q + LEN_W'(1);
                        if (cmd_q == CMD_BUTTON) begin
                            arg_sr_d = {19'b0, btn_onehot};
                        end else if (is_digit) begin
                            arg_sr_d = {arg_sr_q[19:0], digit_val};
                        end
                    end
                end else if (timeout_hit) begin
                    to_cnt_d    = '0;
                    state_d     = ST_IDLE;
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            ST_DISCARD: begin
                if (i_rx_valid) begin
                    to_cnt_d = '0;
                    if (is_term) begin
                        state_d     = ST_IDLE;
                        err_valid_d = 1'b1;
                        err_code_d  = err_q;
                    end else if (len_full) begin
                        err_d = ERR_OVERFLOW;
                    end else begin
                        len_d = len_q + LEN_W'(1);
                    end
                end else if (timeout_hit) begin
                    to_cnt_d    = '0;
                    state_d     = ST_IDLE;
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_NONE;
            err_q       <= ERR_TIMEOUT;
            pos_q       <= 4'd0;
            len_q       <= '0;
            arg_sr_q    <= 24'h0;
            to_cnt_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 2'd0;
            cmd_arg_q   <= 32'h0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            err_q       <= err_d;
            pos_q       <= pos_d;
            len_q       <= len_d;
            arg_sr_q    <= arg_sr_d;
            to_cnt_q    <= to_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_arg_q   <= cmd_arg_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign o_cmd_valid   = cmd_valid_q;
    assign o_cmd_code    = cmd_code_q;
    assign o_cmd_arg     = cmd_arg_q;
    assign o_err_valid   = err_valid_q;
    assign o_err_code    = err_code_q;
    assign o_line_active = (state_q != ST_IDLE);

endmodule
